mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencer between the control unit and the MAR/MDR pair plus the synchronous data memory.
- Takes one read or write request at a time and generates the MAR load, MDR load and MDR source-select enables, and the memory strobes.
- Waits for the memory ready handshake, with a bounded timeout.
- Reports done or error back to the control unit; sits beside the datapath bus and drives only enables and strobes, never data.

Parameters:
- TIMEOUT, 15, maximum number of cycles a memory strobe is held waiting for mem_ready before an error is flagged (1..255).
- CNT_WIDTH, 8, width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-low reset; clear=0 at a rising edge resets the block.
- rd_req  in  1  control unit requests a memory read; sampled only in IDLE.
- wr_req  in  1  control unit requests a memory write; sampled only in IDLE.
- mem_ready  in  1  memory has completed the strobed access this cycle.
- mar_en  out  1  enable for the MAR register (loads address from bus).
- mdr_en  out  1  enable for the MDR register.
- mdr_read  out  1  MDR source select: 1 = memory data, 0 = bus.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (clear=0 at a rising edge): state=IDLE, counter=0, all outputs 0. Reset mid-access aborts immediately; no done or err pulse is produced.
- All outputs are registered Moore decodes of state, i.e. valid the cycle after state entry.
- IDLE:
  - rd_req=1 -> LOAD_MAR with op=RD.
  - Else wr_req=1 -> LOAD_MAR with op=WR.
  - Both high -> read wins; the write is ignored and must be re-requested.
- LOAD_MAR (1 cycle):
  - Outputs: mar_en=1.
  - Next state: op=RD -> RD_WAIT; op=WR -> WR_LOAD.
- WR_LOAD (1 cycle):
  - Outputs: mdr_en=1, mdr_read=0 (MDR captures the bus).
  - Next state: WR_WAIT.
- RD_WAIT:
  - Outputs: mem_rd=1, mdr_read=1.
  - Counter increments each cycle.
  - mem_ready=1 -> CAPTURE.
  - Counter reaching TIMEOUT without ready -> FAULT.
- WR_WAIT:
  - Outputs: mem_wr=1.
  - Same counter and timeout rule.
  - mem_ready=1 -> FINISH.
  - Timeout -> FAULT.
- CAPTURE (1 cycle):
  - Outputs: mdr_en=1, mdr_read=1 (MDR captures memory data).
  - Next state: FINISH.
- FINISH (1 cycle):
  - Outputs: done=1.
  - Next state: IDLE.
- FAULT (1 cycle):
  - Outputs: err=1.
  - Next state: IDLE.
- Counter rules:
  - Cleared on entry to RD_WAIT and WR_WAIT.
  - Saturates; it never wraps.
  - mem_ready and timeout in the same cycle -> ready wins.
- Ready with zero wait: mem_ready=1 in the first wait cycle is accepted.
- mem_ready outside a wait state is ignored.
- Requests arriving while busy=1 are ignored (no queueing).
- Minimum latency, request edge to done pulse:
  - Read: IDLE->LOAD_MAR->RD_WAIT->CAPTURE->FINISH, done 4 cycles after the request is sampled.
  - Write: IDLE->LOAD_MAR->WR_LOAD->WR_WAIT->FINISH, done 4 cycles after the request is sampled.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE, LOAD_MAR, WR_LOAD, RD_WAIT, WR_WAIT, CAPTURE, FINISH, FAULT (3-bit).
  - Op encoding: RD=0, WR=1.
- One natural sub-module: wait_timer (clear-on-start saturating counter with TIMEOUT compare, output expired).
- FSM and output decode stay in mem_access_ctrl.

Test Plan:
- Read, mem_ready on first RD_WAIT cycle -> mar_en 1 cycle, mem_rd 1 cycle, then mdr_en=1 with mdr_read=1, done pulses 4 cycles after request, busy falls same cycle state returns to IDLE.
- Write, mem_ready after 3 wait cycles -> mar_en, then mdr_en with mdr_read=0, mem_wr held exactly 4 cycles, done pulse, mdr_en never asserted with mdr_read=1.
- Read with mem_ready never asserted, TIMEOUT=15 -> mem_rd high 15 cycles, err pulse 1 cycle, no done, mdr_en never high in RD phase.
- rd_req and wr_req high together in IDLE -> read sequence only, mem_wr stays 0 throughout.
- clear=0 during RD_WAIT -> next cycle all outputs 0, state IDLE, no done/err; new rd_req after clear=1 runs normally.
- mem_ready and timeout coincide (ready on cycle 15) -> CAPTURE then done, no err; new request during busy ignored.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access sequencer:
// state/op encodings and the registered output bundle.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_MAR = 3'd1,
        WR_LOAD  = 3'd2,
        RD_WAIT  = 3'd3,
        WR_WAIT  = 3'd4,
        CAPTURE  = 3'd5,
        FINISH   = 3'd6,
        FAULT    = 3'd7
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef struct packed {
        logic mar_en;
        logic mdr_en;
        logic mdr_read;
        logic mem_rd;
        logic mem_wr;
        logic busy;
        logic done;
        logic err;
    } ctrl_out_t;

    function automatic ctrl_out_t decode(state_e s);
        ctrl_out_t o;
        o = '0;
        o.busy = (s != IDLE);
        unique case (s)
            IDLE:     ;
            LOAD_MAR: o.mar_en = 1'b1;
            WR_LOAD:  o.mdr_en = 1'b1;
            RD_WAIT: begin
                o.mem_rd   = 1'b1;
                o.mdr_read = 1'b1;
            end
            WR_WAIT:  o.mem_wr = 1'b1;
            CAPTURE: begin
                o.mdr_en   = 1'b1;
                o.mdr_read = 1'b1;
            end
            FINISH:   o.done = 1'b1;
            FAULT:    o.err  = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the control unit / memory side
// and the access sequencer.
interface mem_access_ctrl_if;

    logic rd_req;
    logic wr_req;
    logic mem_ready;
    logic mar_en;
    logic mdr_en;
    logic mdr_read;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    modport master (
        output rd_req, wr_req, mem_ready,
        input  mar_en, mdr_en, mdr_read,
        input  mem_rd, mem_wr, busy, done, err
    );

    modport slave (
        input  rd_req, wr_req, mem_ready,
        output mar_en, mdr_en, mdr_read,
        output mem_rd, mem_wr, busy, done, err
    );

endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// Saturating wait counter, cleared while start is high;
// expired flags the last permitted wait cycle.
module mem_access_ctrl_wait_timer #(
    parameter int TIMEOUT   = 15,
    parameter int CNT_WIDTH = 8
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR/memory access sequencer: one request at a time,
// outputs are registered decodes of the current state.
module mem_access_ctrl #(
    parameter int TIMEOUT   = 15,
    parameter int CNT_WIDTH = 8
) (
    input logic              clock,
    input logic              clear,
    mem_access_ctrl_if.slave bus
);

    import mem_access_ctrl_pkg::*;

    state_e    state_d;
    state_e    state_q;
    op_e       op_d;
    op_e       op_q;
    ctrl_out_t out_d;
    ctrl_out_t out_q;
    logic      in_wait;
    logic      expired;

    assign in_wait = (state_q == RD_WAIT) ||
                     (state_q == WR_WAIT);

    // Counter sits at zero outside the wait states, so each
    // wait starts from a fresh count.
    mem_access_ctrl_wait_timer #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clock   (clock),
        .clear   (clear),
        .start   (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        out_d   = decode(state_q);
        unique case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    state_d = LOAD_MAR;
                    op_d    = OP_RD;
                end else if (bus.wr_req) begin
                    state_d = LOAD_MAR;
                    op_d    = OP_WR;
                end
            end
            LOAD_MAR: begin
                state_d = (op_q == OP_RD) ? RD_WAIT : WR_LOAD;
            end
            WR_LOAD: state_d = WR_WAIT;
            RD_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = CAPTURE;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            WR_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = FINISH;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            CAPTURE: state_d = FINISH;
            FINISH:  state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign bus.mar_en   = out_q.mar_en;
    assign bus.mdr_en   = out_q.mdr_en;
    assign bus.mdr_read = out_q.mdr_read;
    assign bus.mem_rd   = out_q.mem_rd;
    assign bus.mem_wr   = out_q.mem_wr;
    assign bus.busy     = out_q.busy;
    assign bus.done     = out_q.done;
    assign bus.err      = out_q.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: each access is turned
// into an expected per-cycle output trace and compared.
module tb_mem_access_ctrl;

    localparam int T = 15;

    // {mar_en,mdr_en,mdr_read,mem_rd,mem_wr,busy,done,err}
    localparam logic [7:0] V_IDLE = 8'b0000_0000;
    localparam logic [7:0] V_MAR  = 8'b1000_0100;
    localparam logic [7:0] V_WRLD = 8'b0100_0100;
    localparam logic [7:0] V_RD   = 8'b0011_0100;
    localparam logic [7:0] V_WR   = 8'b0000_1100;
    localparam logic [7:0] V_CAP  = 8'b0110_0100;
    localparam logic [7:0] V_DONE = 8'b0000_0110;
    localparam logic [7:0] V_ERR  = 8'b0000_0101;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   fails  = 0;
    int   txn    = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT   (T),
        .CNT_WIDTH (8)
    ) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {bus.mar_en, bus.mdr_en, bus.mdr_read,
                bus.mem_rd, bus.mem_wr, bus.busy,
                bus.done, bus.err};
    endfunction

    task automatic check(input string tag,
                         input logic [7:0] exp);
        logic [7:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b",
                   tag, o, exp);
        end
    endtask

    // k = wait cycle (0-based) in which mem_ready arrives;
    // k >= T means the memory never answers.
    task automatic run_txn(input bit is_wr,
                           input bit both,
                           input int k);
        logic [7:0] exp[$];
        int w;
        int first_w;
        int rdy_edge;
        bit ok;
        ok = (k < T);
        w  = ok ? k + 1 : T;
        exp.push_back(V_IDLE);
        exp.push_back(V_MAR);
        if (is_wr) exp.push_back(V_WRLD);
        for (int j = 0; j < w; j++)
            exp.push_back(is_wr ? V_WR : V_RD);
        if (ok && !is_wr) exp.push_back(V_CAP);
        exp.push_back(ok ? V_DONE : V_ERR);
        exp.push_back(V_IDLE);
        first_w  = is_wr ? 3 : 2;
        rdy_edge = ok ? first_w + k : -1;
        for (int i = 0; i < exp.size(); i++) begin
            if (i == 0) begin
                bus.rd_req = !is_wr;
                bus.wr_req = is_wr ? 1'b1
                           : (both ? 1'b1 : 1'($urandom));
            end else if (i < exp.size() - 1) begin
                bus.rd_req = 1'($urandom);
                bus.wr_req = 1'($urandom);
            end else begin
                bus.rd_req = 1'b0;
                bus.wr_req = 1'b0;
            end
            if (i >= first_w && i < first_w + w)
                bus.mem_ready = (i == rdy_edge);
            else
                bus.mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("txn%0d_%s_k%0d_c%0d", txn,
                  is_wr ? "wr" : "rd", k, i), exp[i]);
        end
        bus.rd_req    = 1'b0;
        bus.wr_req    = 1'b0;
        bus.mem_ready = 1'b0;
        txn++;
    endtask

    initial begin
        clear         = 1'b0;
        bus.rd_req    = 1'b0;
        bus.wr_req    = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs", V_IDLE);
        bus.rd_req    = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ignores_req", V_IDLE);
        bus.rd_req    = 1'b0;
        bus.mem_ready = 1'b0;
        clear         = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", V_IDLE);

        run_txn(1'b0, 1'b0, 0);
        run_txn(1'b1, 1'b0, 3);
        run_txn(1'b0, 1'b0, T + 5);
        run_txn(1'b1, 1'b0, T + 5);
        run_txn(1'b0, 1'b1, 0);
        run_txn(1'b0, 1'b1, 2);

        // Abort a read in its wait phase.
        for (int i = 0; i < 7; i++) begin
            bus.rd_req    = (i == 0);
            bus.mem_ready = 1'b0;
            if (i == 6) begin
                clear         = 1'b0;
                bus.rd_req    = 1'b1;
                bus.mem_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i == 0)
                check("abort_c0", V_IDLE);
            else if (i == 1)
                check("abort_c1", V_MAR);
            else if (i < 6)
                check($sformatf("abort_c%0d", i), V_RD);
            else
                check("abort_cleared", V_IDLE);
        end
        clear         = 1'b1;
        bus.rd_req    = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_quiet_c%0d", i), V_IDLE);
        end
        run_txn(1'b0, 1'b0, 1);

        run_txn(1'b0, 1'b0, T - 1);
        run_txn(1'b1, 1'b0, T - 1);
        run_txn(1'b1, 1'b0, 0);
        run_txn(1'b1, 1'b0, T);

        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom), 1'($urandom),
                    int'($urandom_range(0, T + 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
